// File: rtl/register_file_be.sv
// register_file_be: byte-enabled register file with location 0 reading as zero,
// optional same-cycle write-to-read bypass, and a sequential clear engine that
// zeroes every location after reset or on request.
//
// Handshake note: there is no valid/ready pair. `busy` is a level stall
// indication. While busy=1, wr is ignored and nothing is queued, so the
// writeback stage must hold its write until busy=0. `done` is a single-cycle
// pulse in the first IDLE cycle after a clear pass.
module register_file_be #(
  parameter int Abits  = 5,
  parameter int Dbits  = 32,
  parameter int Nloc   = 32,
  parameter int BYPASS = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr,
  input  logic [Dbits/8-1:0] wbe,
  input  logic [Abits-1:0]   WriteAddr,
  input  logic [Dbits-1:0]   WriteData,
  input  logic [Abits-1:0]   ReadAddr1,
  input  logic [Abits-1:0]   ReadAddr2,
  output logic [Dbits-1:0]   ReadData1,
  output logic [Dbits-1:0]   ReadData2,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic               state_dbg_o
);

  localparam int NB = Dbits / 8;
  localparam logic [Abits:0]   NLOC_W = (Abits + 1)'(Nloc);
  localparam logic [Abits-1:0] LAST   = Abits'(Nloc - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [Abits-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [Dbits-1:0]  mem_q [Nloc];
  logic              wr_eff;

  // Location 0 and locations at or above Nloc are not backed by storage.
  function automatic logic in_range(input logic [Abits-1:0] a);
    return (a != '0) && ({1'b0, a} < NLOC_W);
  endfunction

  // Byte-lane merge: new bytes where the enable is set, old bytes elsewhere.
  function automatic logic [Dbits-1:0] merge(input logic [Dbits-1:0] old_v,
                                             input logic [Dbits-1:0] new_v,
                                             input logic [NB-1:0]    be);
    logic [Dbits-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign busy        = (state_q == CLEAR);
  assign done        = done_q;
  assign state_dbg_o = state_q;
  assign wr_eff      = !busy && wr && (|wbe) && in_range(WriteAddr);

  // Clear engine next state: walk the counter to Nloc-1, then fall to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + Abits'(1);
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Clear engine state register; reset starts a fresh pass from location 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Storage update: clear pass zeroes one location per cycle, otherwise byte writes.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_eff) begin
      mem_q[WriteAddr] <= merge(mem_q[WriteAddr], WriteData, wbe);
    end
  end

  // Read port 1: zero when busy or unbacked, bypass merge on a same-address write.
  always_comb begin
    ReadData1 = '0;
    if (!busy && in_range(ReadAddr1)) begin
      if (BYPASS != 0 && wr_eff && WriteAddr == ReadAddr1) begin
        ReadData1 = merge(mem_q[ReadAddr1], WriteData, wbe);
      end else begin
        ReadData1 = mem_q[ReadAddr1];
      end
    end
  end

  // Read port 2: same rules as port 1, independent address.
  always_comb begin
    ReadData2 = '0;
    if (!busy && in_range(ReadAddr2)) begin
      if (BYPASS != 0 && wr_eff && WriteAddr == ReadAddr2) begin
        ReadData2 = merge(mem_q[ReadAddr2], WriteData, wbe);
      end else begin
        ReadData2 = mem_q[ReadAddr2];
      end
    end
  end

endmodule

// File: tb/tb_register_file_be.sv
// Bench for register_file_be: two instances share stimulus, one with
// Nloc=32/BYPASS=1 and one with Nloc=24/BYPASS=0, each against its own model.
module tb_register_file_be;

  localparam int NI = 2;
  localparam int EW = 66;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic        wr;
  logic [3:0]  wbe;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1, ra2;
  logic        clear;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        busy_0, done_0, dbg_0, busy_1, done_1, dbg_1;

  register_file_be #(.Abits(5), .Dbits(32), .Nloc(32), .BYPASS(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .wr(wr), .wbe(wbe), .WriteAddr(wa),
    .WriteData(wd), .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(rd1_0),
    .ReadData2(rd2_0), .clear(clear), .busy(busy_0), .done(done_0),
    .state_dbg_o(dbg_0)
  );

  register_file_be #(.Abits(5), .Dbits(32), .Nloc(24), .BYPASS(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .wr(wr), .wbe(wbe), .WriteAddr(wa),
    .WriteData(wd), .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(rd1_1),
    .ReadData2(rd2_1), .clear(clear), .busy(busy_1), .done(done_1),
    .state_dbg_o(dbg_1)
  );

  // ---------------- reference model ----------------
  // Clearing is modelled as "cycles of unavailability left"; the whole file
  // becomes zero when that reaches 0.
  logic [31:0] mm [NI][32];
  int          rem [NI];
  bit          mdone [NI];

  function automatic int nloc_of(input int j);
    return (j == 0) ? 32 : 24;
  endfunction

  function automatic bit byp_of(input int j);
    return (j == 0);
  endfunction

  function automatic logic [31:0] merge_m(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mask = mask | (32'hFF << (8 * b));
    end
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic bit write_ok(input int j);
    return rem[j] == 0 && wr && wbe != 4'h0 && wa != 5'd0 && int'(wa) < nloc_of(j);
  endfunction

  function automatic logic [31:0] exp_read(input int j, input logic [4:0] ra);
    if (rem[j] > 0 || ra == 5'd0 || int'(ra) >= nloc_of(j)) return 32'h0;
    if (byp_of(j) && write_ok(j) && wa == ra) return merge_m(mm[j][ra], wd, wbe);
    return mm[j][ra];
  endfunction

  task automatic model_edge(input int j);
    if (rem[j] > 0) begin
      rem[j]   = rem[j] - 1;
      mdone[j] = 1'b0;
      if (rem[j] == 0) begin
        for (int k = 0; k < 32; k++) mm[j][k] = 32'h0;
        mdone[j] = 1'b1;
      end
    end else begin
      mdone[j] = 1'b0;
      if (write_ok(j)) mm[j][wa] = merge_m(mm[j][wa], wd, wbe);
      if (clear) rem[j] = nloc_of(j);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [NI*EW-1:0] exp_q[$];
  int checks;
  int errors;
  int cyc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d got %08h exp %08h", name, cyc, got, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  always @(negedge clock) begin
    logic [NI*EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy0",  {31'h0, busy_0}, {31'h0, e[65]});
      chk("state0", {31'h0, dbg_0},  {31'h0, e[65]});
      chk("done0",  {31'h0, done_0}, {31'h0, e[64]});
      chk("rd1_0",  rd1_0, e[63:32]);
      chk("rd2_0",  rd2_0, e[31:0]);
      chk("busy1",  {31'h0, busy_1}, {31'h0, e[EW+65]});
      chk("state1", {31'h0, dbg_1},  {31'h0, e[EW+65]});
      chk("done1",  {31'h0, done_1}, {31'h0, e[EW+64]});
      chk("rd1_1",  rd1_1, e[EW+63:EW+32]);
      chk("rd2_1",  rd2_1, e[EW+31:EW]);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; applies inputs, predicts, and advances one cycle.
  task automatic step(input logic rn, input logic w, input logic [3:0] be,
                      input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic clr);
    logic [NI*EW-1:0] e;
    reset_n = rn; wr = w; wbe = be; wa = a; wd = d; ra1 = r1; ra2 = r2; clear = clr;
    if (!rn) begin
      for (int j = 0; j < NI; j++) begin
        rem[j]   = nloc_of(j);
        mdone[j] = 1'b0;
      end
    end
    for (int j = 0; j < NI; j++) begin
      e[j*EW +: EW] = {rem[j] > 0, mdone[j], exp_read(j, r1), exp_read(j, r2)};
    end
    exp_q.push_back(e);
    @(posedge clock);
    if (rn) begin
      for (int j = 0; j < NI; j++) model_edge(j);
    end
    cyc++;
    #1;
  endtask

  task automatic wr_step(input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [4:0] r1);
    step(1'b1, 1'b1, be, a, d, r1, 5'($urandom_range(0, 31)), 1'b0);
  endtask

  task automatic idle_step(input logic clr);
    step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), clr);
  endtask

  task automatic rand_step(input int clr_odds);
    logic [4:0] a;
    a = 5'($urandom_range(0, 31));
    step(1'b1, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, $urandom,
         ($urandom_range(0, 1) != 0) ? a : 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), $urandom_range(0, clr_odds) == 0);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'(2 * i), 5'(2 * i + 1), 1'b0);
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && (rem[0] != 0 || rem[1] != 0); n++) idle_step(1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset_n = 1'b0; wr = 1'b0; wbe = 4'h0; wa = 5'd0; wd = 32'h0;
    ra1 = 5'd0; ra2 = 5'd0; clear = 1'b0;
    for (int j = 0; j < NI; j++) begin
      rem[j] = nloc_of(j);
      mdone[j] = 1'b0;
      for (int k = 0; k < 32; k++) mm[j][k] = 32'h0;
    end
    @(posedge clock);
    #1;

    // Reset held, then release: pass of Nloc cycles with random writes that must drop.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0);
    for (int i = 0; i < 40; i++) rand_step(1000000);
    wait_idle();
    sweep();

    // Byte-enable merge, location 0 stays zero.
    wr_step(5'd5, 32'hDEADBEEF, 4'hF, 5'd5);
    wr_step(5'd5, 32'h00000011, 4'h1, 5'd5);
    step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
    wr_step(5'd0, 32'hFFFFFFFF, 4'hF, 5'd0);
    step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);

    // Bypass vs. stored value on a same-cycle write.
    wr_step(5'd7, 32'hAAAAAAAA, 4'hF, 5'd0);
    wr_step(5'd7, 32'h12345678, 4'hC, 5'd7);
    step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);

    // Address beyond Nloc of the smaller instance.
    wr_step(5'd30, 32'h55555555, 4'hF, 5'd30);
    step(1'b1, 1'b0, 4'h0, 5'd0, 32'h0, 5'd30, 5'd23, 1'b0);

    // Fill everything, then clear; writes during the pass drop, a second clear mid-pass is ignored.
    for (int i = 1; i < 32; i++) wr_step(5'(i), $urandom | 32'h1, 4'hF, 5'(i));
    sweep();
    idle_step(1'b1);
    for (int i = 0; i < 10; i++) rand_step(1000000);
    idle_step(1'b1);
    for (int i = 0; i < 10; i++) rand_step(1000000);
    wait_idle();
    sweep();

    // Clear requested in the very cycle done is high.
    idle_step(1'b1);
    for (int n = 0; n < 100 && !mdone[0]; n++) idle_step(1'b0);
    idle_step(1'b1);
    for (int i = 0; i < 5; i++) idle_step(1'b0);
    wait_idle();

    // Reset mid-pass at counter 10 restarts a full pass.
    for (int i = 1; i < 32; i++) wr_step(5'(i), $urandom, 4'($urandom_range(1, 15)), 5'(i));
    idle_step(1'b1);
    for (int i = 0; i < 10; i++) rand_step(1000000);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'hF, 5'd3, 32'h1, 5'd3, 5'd4, 1'b0);
    for (int i = 0; i < 40; i++) rand_step(1000000);
    sweep();

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) rand_step(40);
    wait_idle();
    sweep();

    @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
